// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling
//
// Purpose: converts an asynchronous 8N1 serial stream on rx into a parallel
// byte. Each completed frame is reported with a one-cycle rxDone strobe, and
// right tells whether the stop bit was high.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   rxEn     in   receive enable; low forces/keeps the receiver idle
//   rx       in   asynchronous serial line, idles high
//   out_data out  last received byte (updated on every completed frame)
//   rxBusy   out  high while a frame is in progress
//   rxDone   out  one-cycle pulse when a frame completes
//   right    out  stop bit was high; valid from rxDone until next frame start
module uart_receiver #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxEn,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       right
);

  localparam int CW = ($clog2(CLKS_PER_BIT) < 9) ? 9 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic          sync1, sync2, prev;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  logic line, fall, half_tick, full_tick;

  assign line      = sync2;
  assign fall      = prev & ~sync2;
  assign half_tick = (cnt == HALF_M1);
  assign full_tick = (cnt == FULL_M1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      state <= state_next;
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_comb begin
    state_next = state;
    rxBusy     = (state != IDLE);
    rxDone     = (state == DONE);
    case (state)
      IDLE:  if (rxEn && fall) state_next = START;
      START: if (half_tick) state_next = line ? IDLE : DATA;
      DATA:  if (full_tick && idx == 3'd7) state_next = STOP;
      STOP:  if (full_tick) state_next = DONE;
      // An edge seen during DONE would be lost by the one-cycle edge detector
      // if we passed through IDLE first, so start the next frame directly.
      DONE:  state_next = (rxEn && fall) ? START : IDLE;
      default: state_next = IDLE;
    endcase
    if (!rxEn && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      out_data <= '0;
      right    <= 1'b0;
    end else begin
      // The bit-period counter restarts on every state change and at each
      // data-bit sample, so every phase measures from its own entry.
      if (state == IDLE || state_next != state || (state == DATA && full_tick))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state != DATA)
        idx <= '0;
      else if (full_tick)
        idx <= idx + 1'b1;

      if (state == DATA && full_tick)
        shreg[idx] <= line;

      if (state == STOP && state_next == DONE) begin
        out_data <= shreg;
        right    <= line;
      end else if (state_next == START && state != START) begin
        right <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int BIT_CYC = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxEn = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] out_data;
  logic       rxBusy;
  logic       rxDone;
  logic       right;

  uart_receiver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxEn     (rxEn),
    .rx       (rx),
    .out_data (out_data),
    .rxBusy   (rxBusy),
    .rxDone   (rxDone),
    .right    (right)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard entries: {right, data}
  logic [8:0] exp_q[$];

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc_prev = 0;
  int done_cyc_last = 0;
  int busy_run = 0;
  int last_busy_len = 0;
  logic busy_seen = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rxDone) begin
      done_cnt++;
      done_cyc_prev = done_cyc_last;
      done_cyc_last = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rxDone", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
        check("right", {31'd0, right}, {31'd0, e[8]});
      end
    end
    if (rxBusy) begin
      busy_run++;
      busy_seen = 1'b1;
    end else begin
      if (busy_run != 0) last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    logic [7:0] d;

    // Reset
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_out_data", {24'd0, out_data}, 32'h00);
    check("rst_rxBusy", {31'd0, rxBusy}, 32'd0);
    check("rst_rxDone", {31'd0, rxDone}, 32'd0);
    check("rst_right", {31'd0, right}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single frame 0xB5: bits 0,1,0,1,0,1,1,0,1,1
    exp_q.push_back({1'b1, 8'hB5});
    send_frame(8'hB5, 1'b1);
    idle(200);
    check("b5_done_count", done_cnt, 32'd1);
    check("b5_busy_len", last_busy_len, 32'd4124);

    // Back-to-back 0x00, 0xFF with no idle gap
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(200);
    check("b2b_done_count", done_cnt, 32'd3);
    check("b2b_gap_ok", {31'd0, (done_cyc_last - done_cyc_prev >= 4338) &&
                               (done_cyc_last - done_cyc_prev <= 4342)}, 32'd1);

    // Glitch: low for 100 cycles is a false start
    busy_seen = 1'b0;
    base = done_cnt;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(400);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_no_done", done_cnt, base);
    check("glitch_out_data", {24'd0, out_data}, 32'hFF);

    // Framing error 0x3C then line held low (break)
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b0);
    base = done_cnt;
    rx = 1'b0;
    repeat (20000) @(negedge clk);
    check("break_no_retrigger", done_cnt, base);
    idle(200);

    // Receiver disabled while 0x55 is sent
    rxEn = 1'b0;
    busy_seen = 1'b0;
    base = done_cnt;
    send_frame(8'h55, 1'b1);
    idle(200);
    check("dis_busy_seen", {31'd0, busy_seen}, 32'd0);
    check("dis_no_done", done_cnt, base);
    rxEn = 1'b1;
    idle(50);

    // rxEn dropped mid-frame
    d = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    check("abort_busy_before", {31'd0, rxBusy}, 32'd1);
    rxEn = 1'b0;
    @(negedge clk);
    check("abort_busy_next", {31'd0, rxBusy}, 32'd0);
    for (int i = 3; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    idle(100);
    rxEn = 1'b1;
    idle(500);
    check("abort_no_done", done_cnt, base);
    check("abort_out_data", {24'd0, out_data}, 32'h3C);
    check("abort_right", {31'd0, right}, 32'd0);

    // Reset mid-frame, then a clean 0xA5
    d = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("mrst_out_data", {24'd0, out_data}, 32'h00);
    check("mrst_rxBusy", {31'd0, rxBusy}, 32'd0);
    check("mrst_rxDone", {31'd0, rxDone}, 32'd0);
    check("mrst_right", {31'd0, right}, 32'd0);
    rst_n = 1'b1;
    idle(1000);
    exp_q.push_back({1'b1, 8'hA5});
    send_frame(8'hA5, 1'b1);
    idle(500);

    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_done_count", done_cnt, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
